imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch_if.sv | 29 ++
 rtl/imem_fetch.sv | 81 ++++++++
 tb/tb_imem_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Fetch-port bundle for imem_fetch: request/response handshake plus program-load write port.
// master = fetch requester / loader, slave = the instruction memory.
interface imem_fetch_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int ADDR_W      = 10
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDR_W-1:0]        req_addr;
    logic                     flush;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [32*FETCH_WIDTH-1:0] rsp_instr;
    logic [ADDR_W-1:0]        rsp_addr;
    logic [FETCH_WIDTH-1:0]   rsp_lane_valid;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [31:0]              wr_data;

    modport master (
        output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_lane_valid
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_lane_valid
    );
endinterface

// File: rtl/imem_fetch.sv
// Instruction memory with a one-cycle, FETCH_WIDTH-wide fetch port and a program-load write port.
// Optional macro IMEM_WR_BYPASS_EN forwards a same-cycle write into the fetched lanes.
module imem_fetch #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input logic         clk,
    input logic         rst,
    imem_fetch_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    // Memory powers up filled with NOPs; reset never touches it.
    logic [31:0] mem [DEPTH] = '{default: NOP_INSTR};

    logic                      accept_p0;
    logic [ADDR_W+1:0]         addr_ext_p0;
    logic [32*FETCH_WIDTH-1:0] fetch_instr_p0;
    logic [FETCH_WIDTH-1:0]    fetch_lv_p0;

    logic                      vld_p1;
    logic [32*FETCH_WIDTH-1:0] rsp_instr_p1;
    logic [ADDR_W-1:0]         rsp_addr_p1;
    logic [FETCH_WIDTH-1:0]    rsp_lv_p1;

    // Two guard bits so base + lane never wraps back into the legal range.
    function automatic logic [ADDR_W+1:0] lane_addr(input logic [ADDR_W-1:0] base, input int lane);
        return {2'b00, base} + (ADDR_W+2)'(lane);
    endfunction

    assign bus.req_ready = !rst && (!vld_p1 || bus.rsp_ready || bus.flush);
    assign accept_p0     = bus.req_valid && bus.req_ready;

    // ---- stage p0: lane address generation and memory read
    always_comb begin
        addr_ext_p0    = '0;
        fetch_instr_p0 = '0;
        fetch_lv_p0    = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            addr_ext_p0 = lane_addr(bus.req_addr, i);
            if (addr_ext_p0[ADDR_W+1:ADDR_W] != 2'b00) begin
                fetch_instr_p0[32*i +: 32] = NOP_INSTR;
            end else begin
                fetch_lv_p0[i]             = 1'b1;
                fetch_instr_p0[32*i +: 32] = mem[addr_ext_p0[ADDR_W-1:0]];
`ifdef IMEM_WR_BYPASS_EN
                if (bus.wr_en && (bus.wr_addr == addr_ext_p0[ADDR_W-1:0]))
                    fetch_instr_p0[32*i +: 32] = bus.wr_data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    // ---- stage p1: registered response, held until consumed or flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            rsp_instr_p1 <= {FETCH_WIDTH{NOP_INSTR}};
            rsp_addr_p1  <= '0;
            rsp_lv_p1    <= '0;
        end else if (accept_p0) begin
            vld_p1       <= 1'b1;
            rsp_instr_p1 <= fetch_instr_p0;
            rsp_addr_p1  <= bus.req_addr;
            rsp_lv_p1    <= fetch_lv_p0;
        end else if (bus.rsp_ready || bus.flush) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.rsp_valid      = vld_p1;
    assign bus.rsp_instr      = rsp_instr_p1;
    assign bus.rsp_addr       = rsp_addr_p1;
    assign bus.rsp_lane_valid = rsp_lv_p1;
endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: a 4-wide and a 2-wide instance, directed vectors,
// expected responses queued at request time and checked by per-instance monitors.
module tb_imem_fetch;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_WR_BYPASS_EN
    localparam logic [31:0] BYP_LANE0 = 32'h00a00c13;
`else
    localparam logic [31:0] BYP_LANE0 = 32'h00500513;
`endif

    typedef struct {
        logic [9:0]   addr;
        logic [127:0] instr;
        logic [3:0]   lv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q4[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    imem_fetch_if #(.FETCH_WIDTH(4), .ADDR_W(10)) bus4 ();
    imem_fetch_if #(.FETCH_WIDTH(2), .ADDR_W(10)) bus2 ();

    imem_fetch #(.FETCH_WIDTH(4), .ADDR_W(10), .NOP_INSTR(NOP)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    imem_fetch #(.FETCH_WIDTH(2), .ADDR_W(10), .NOP_INSTR(NOP)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_both(input logic [9:0] a, input logic [31:0] d);
        bus4.wr_en = 1'b1; bus4.wr_addr = a; bus4.wr_data = d;
        bus2.wr_en = 1'b1; bus2.wr_addr = a; bus2.wr_data = d;
        step();
        bus4.wr_en = 1'b0;
        bus2.wr_en = 1'b0;
    endtask

    task automatic req4(input logic [9:0] a, input logic [127:0] ei, input logic [3:0] el);
        bus4.req_valid = 1'b1;
        bus4.req_addr  = a;
        #1;
        chk("req4_ready", 128'(bus4.req_ready), 128'(1'b1));
        q4.push_back('{addr: a, instr: ei, lv: el});
    endtask

    // Monitors: compare the presented response every cycle it is valid (so a held
    // response must stay stable) and retire it on consume, flush or reset.
    always @(negedge clk) begin
        if (bus4.rsp_valid === 1'b1) begin
            if (q4.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL rsp4_unexpected: got response addr %0d, expected none outstanding", bus4.rsp_addr);
            end else begin
                chk("rsp4_instr", bus4.rsp_instr, q4[0].instr);
                chk("rsp4_addr", 128'(bus4.rsp_addr), 128'(q4[0].addr));
                chk("rsp4_lane_valid", 128'(bus4.rsp_lane_valid), 128'(q4[0].lv));
                if (bus4.rsp_ready || bus4.flush || rst) void'(q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.rsp_valid === 1'b1) begin
            if (q2.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL rsp2_unexpected: got response addr %0d, expected none outstanding", bus2.rsp_addr);
            end else begin
                chk("rsp2_instr", 128'(bus2.rsp_instr), 128'(q2[0].instr[63:0]));
                chk("rsp2_addr", 128'(bus2.rsp_addr), 128'(q2[0].addr));
                chk("rsp2_lane_valid", 128'(bus2.rsp_lane_valid), 128'(q2[0].lv[1:0]));
                if (bus2.rsp_ready || bus2.flush || rst) void'(q2.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_addr = '0; bus4.flush = 1'b0; bus4.rsp_ready = 1'b1;
        bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_data = '0;
        bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.flush = 1'b0; bus2.rsp_ready = 1'b1;
        bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        step();

        // Reset: requests ignored, writes honoured, outputs at reset values
        bus4.req_valid = 1'b1;
        bus4.wr_en = 1'b1; bus4.wr_addr = 10'd0; bus4.wr_data = 32'h00100293;
        bus2.wr_en = 1'b1; bus2.wr_addr = 10'd0; bus2.wr_data = 32'h00100293;
        #1;
        chk("reset_req_ready", 128'(bus4.req_ready), 128'(1'b0));
        step();
        chk("reset_rsp_valid", 128'(bus4.rsp_valid), 128'(1'b0));
        chk("reset_rsp_instr", bus4.rsp_instr, {NOP, NOP, NOP, NOP});
        chk("reset_rsp_addr", 128'(bus4.rsp_addr), 128'(0));
        chk("reset_lane_valid", 128'(bus4.rsp_lane_valid), 128'(0));
        chk("reset_rsp2_instr", 128'(bus2.rsp_instr), 128'({NOP, NOP}));
        bus4.req_valid = 1'b0; bus4.wr_en = 1'b0; bus2.wr_en = 1'b0;
        rst = 1'b0;

        wr_both(10'd1, 32'h00200313);
        wr_both(10'd3, 32'h00300393);
        wr_both(10'd5, 32'h00500513);
        wr_both(10'd8, 32'h00800893);
        wr_both(10'd1022, 32'h11111111);
        wr_both(10'd1023, 32'h22222222);

        // Basic fetch, latency 1, on both widths
        bus2.req_valid = 1'b1; bus2.req_addr = 10'd0;
        q2.push_back('{addr: 10'd0, instr: {64'd0, 32'h00200313, 32'h00100293}, lv: 4'b0011});
        req4(10'd0, {32'h00300393, NOP, 32'h00200313, 32'h00100293}, 4'b1111);
        step();
        chk("latency_rsp4_valid", 128'(bus4.rsp_valid), 128'(1'b1));
        chk("latency_rsp2_valid", 128'(bus2.rsp_valid), 128'(1'b1));
        bus4.req_valid = 1'b0; bus2.req_valid = 1'b0;
        step();
        chk("drain_rsp_valid", 128'(bus4.rsp_valid), 128'(1'b0));

        // Top-of-memory: no wrap, out-of-range lanes filled with NOP
        req4(10'd1022, {NOP, NOP, 32'h22222222, 32'h11111111}, 4'b0011);
        step();
        req4(10'd1023, {NOP, NOP, NOP, 32'h22222222}, 4'b0001);
        step();
        bus4.req_valid = 1'b0;
        step();

        // Backpressure: held response stable despite rewrite of its address
        bus4.rsp_ready = 1'b0;
        req4(10'd1, {NOP, 32'h00300393, NOP, 32'h00200313}, 4'b1111);
        step();
        for (int k = 0; k < 3; k++) begin
            bus4.req_valid = 1'b1; bus4.req_addr = 10'd0;
            bus4.wr_en = 1'b1; bus4.wr_addr = 10'd1; bus4.wr_data = 32'hdeadbeef;
            #1;
            chk("held_req_ready", 128'(bus4.req_ready), 128'(1'b0));
            step();
        end
        bus4.req_valid = 1'b0; bus4.wr_en = 1'b0; bus4.rsp_ready = 1'b1;
        step();
        chk("held_delivered_once", 128'(bus4.rsp_valid), 128'(1'b0));

        // Flush with new request replaces held response
        bus4.rsp_ready = 1'b0;
        req4(10'd3, {NOP, 32'h00500513, NOP, 32'h00300393}, 4'b1111);
        step();
        bus4.flush = 1'b1;
        req4(10'd8, {NOP, NOP, NOP, 32'h00800893}, 4'b1111);
        step();
        bus4.flush = 1'b0; bus4.req_valid = 1'b0;
        chk("flush_new_valid", 128'(bus4.rsp_valid), 128'(1'b1));
        chk("flush_new_addr", 128'(bus4.rsp_addr), 128'(10'd8));
        bus4.rsp_ready = 1'b1;
        step();

        // Flush alone clears the held response
        bus4.rsp_ready = 1'b0;
        req4(10'd0, {32'h00300393, NOP, 32'hdeadbeef, 32'h00100293}, 4'b1111);
        step();
        bus4.req_valid = 1'b0; bus4.flush = 1'b1;
        #1;
        chk("flush_req_ready", 128'(bus4.req_ready), 128'(1'b1));
        step();
        bus4.flush = 1'b0; bus4.rsp_ready = 1'b1;
        chk("flush_only_valid", 128'(bus4.rsp_valid), 128'(1'b0));

        // Same-cycle write and fetch of address 5
        bus4.wr_en = 1'b1; bus4.wr_addr = 10'd5; bus4.wr_data = 32'h00a00c13;
        req4(10'd5, {32'h00800893, NOP, NOP, BYP_LANE0}, 4'b1111);
        step();
        bus4.wr_en = 1'b0;
        req4(10'd5, {32'h00800893, NOP, NOP, 32'h00a00c13}, 4'b1111);
        step();
        bus4.req_valid = 1'b0;
        step();

        // Reset one cycle after acceptance drops the in-flight response
        req4(10'd1022, {NOP, NOP, 32'h22222222, 32'h11111111}, 4'b0011);
        step();
        bus4.req_addr = 10'd0;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 128'(bus4.req_ready), 128'(1'b0));
        step();
        chk("rst_rsp_valid", 128'(bus4.rsp_valid), 128'(1'b0));
        chk("rst_rsp_instr", bus4.rsp_instr, {NOP, NOP, NOP, NOP});
        chk("rst_lane_valid", 128'(bus4.rsp_lane_valid), 128'(0));
        rst = 1'b0; bus4.req_valid = 1'b0;
        step();
        chk("rst_no_stale", 128'(bus4.rsp_valid), 128'(1'b0));

        // Memory survives reset
        req4(10'd1022, {NOP, NOP, 32'h22222222, 32'h11111111}, 4'b0011);
        step();
        bus4.req_valid = 1'b0;
        step();
        step();

        chk("q4_drained", 128'(q4.size()), 128'(0));
        chk("q2_drained", 128'(q2.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
